alu_issue_seq: RTL and testbench

- Sequential issue/writeback stage wrapped around the combinational ALU+barrel datapath (8-bit operands Rn/Rm, 3-bit shift amount, 2-bit barrel op, 2-bit ALUControl, NZCV flags).
- Holds an 8x8 register file and a 4-bit NZCV flag register. Accepts one instruction per handshake and drives the datapath operand/control inputs.
- Captures Rd and NZCV, evaluates the condition code against stored flags, and writes back.
- Executes one instruction at a time; no overlap.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_issue_seq_cond_eval.sv | 44 ++++
 rtl/alu_issue_seq.sv | 215 +++++++++++++++++++++
 tb/tb_alu_issue_seq.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue/writeback stage.
package alu_pkg;

  // Issue sequencer states; one instruction walks through all four in order.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  // Condition-code encodings evaluated against the stored NZCV register.
  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_NE = 4'd2,
    COND_HS = 4'd3,
    COND_LO = 4'd4,
    COND_HI = 4'd5,
    COND_LS = 4'd6,
    COND_GE = 4'd7,
    COND_LT = 4'd8,
    COND_GT = 4'd9,
    COND_LE = 4'd10,
    COND_MI = 4'd11,
    COND_PL = 4'd12,
    COND_NV = 4'd13
  } cond_e;

  // Instruction kinds selected by in_op.
  localparam logic OP_ALU = 1'b0;
  localparam logic OP_LDI = 1'b1;

  // Bit positions inside a {N,Z,C,V} flag vector.
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

endpackage

// File: rtl/alu_issue_seq_cond_eval.sv
// Combinational condition-code evaluator: decides whether an instruction
// executes, given its 4-bit condition and the current {N,Z,C,V} flags.
// Codes 13-15 never pass.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = nzcv[NZCV_N];
  assign z_s = nzcv[NZCV_Z];
  assign c_s = nzcv[NZCV_C];
  assign v_s = nzcv[NZCV_V];

  // Decode the condition field against the individual flag bits.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_HS: pass = c_s;
      COND_LO: pass = ~c_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~c_s | z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = z_s | (n_s != v_s);
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback stage wrapped around the external combinational ALU+barrel
// datapath. Holds the register file and NZCV flags, issues one instruction
// at a time (IDLE -> READ -> EXEC -> WB) and retires it with a one-cycle
// wb_valid pulse on the edge that leaves WB.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int W     = 8,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_op,
  input  logic [3:0]    in_cond,
  input  logic          in_setf,
  input  logic [IW-1:0] in_rd,
  input  logic [IW-1:0] in_rn,
  input  logic [IW-1:0] in_rm,
  input  logic [W-1:0]  in_imm,
  input  logic [2:0]    in_amt,
  input  logic [1:0]    in_opbarrel,
  input  logic [1:0]    in_aluctl,
  output logic [W-1:0]  alu_rn,
  output logic [W-1:0]  alu_rm,
  output logic [2:0]    alu_amt,
  output logic [1:0]    alu_opbarrel,
  output logic [1:0]    alu_ctl,
  input  logic [W-1:0]  alu_rd,
  input  logic [3:0]    alu_nzcv,
  output logic          wb_valid,
  output logic          wb_exec,
  output logic [W-1:0]  wb_data,
  output logic [3:0]    flags,
  input  logic [IW-1:0] dbg_idx,
  output logic [W-1:0]  dbg_data
);

  state_e         state_r;
  logic           in_ready_r;

  // Instruction fields latched at accept; in_* are ignored afterwards.
  logic           op_r;
  logic [3:0]     cond_r;
  logic           setf_r;
  logic [IW-1:0]  rd_r;
  logic [IW-1:0]  rn_r;
  logic [IW-1:0]  rm_r;
  logic [W-1:0]   imm_r;
  logic [2:0]     amt_r;
  logic [1:0]     opbarrel_r;
  logic [1:0]     aluctl_r;

  // Architectural state.
  logic [W-1:0]   regfile_r [NREGS];
  logic [3:0]     flags_r;

  // Datapath operand/control registers driven to the external ALU.
  logic [W-1:0]   alu_rn_r;
  logic [W-1:0]   alu_rm_r;
  logic [2:0]     alu_amt_r;
  logic [1:0]     alu_opbarrel_r;
  logic [1:0]     alu_ctl_r;

  // Per-instruction results.
  logic           cond_pass_r;
  logic [W-1:0]   result_r;
  logic [3:0]     nzcv_r;

  // Retirement outputs.
  logic           wb_valid_r;
  logic           wb_exec_r;
  logic [W-1:0]   wb_data_r;

  // Commit decode.
  logic           cond_pass_s;
  logic           reg_we_s;
  logic           flag_we_s;
  logic [W-1:0]   wb_data_s;

  // Condition is judged against the flags as they stand when operands are read.
  cond_eval u_cond_eval (
    .cond (cond_r),
    .nzcv (flags_r),
    .pass (cond_pass_s)
  );

  // Decide what the retiring instruction writes: LDI never touches flags,
  // a failed condition writes nothing and reports zero data.
  always_comb begin
    wb_data_s = {W{1'b0}};
    reg_we_s  = 1'b0;
    flag_we_s = 1'b0;
    if (cond_pass_r) begin
      reg_we_s = 1'b1;
      if (op_r == OP_LDI) begin
        wb_data_s = imm_r;
        flag_we_s = 1'b0;
      end else begin
        wb_data_s = result_r;
        flag_we_s = setf_r;
      end
    end else begin
      wb_data_s = {W{1'b0}};
      reg_we_s  = 1'b0;
      flag_we_s = 1'b0;
    end
  end

  // Issue sequencer with all architectural state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      in_ready_r     <= 1'b1;
      op_r           <= OP_ALU;
      cond_r         <= 4'd0;
      setf_r         <= 1'b0;
      rd_r           <= {IW{1'b0}};
      rn_r           <= {IW{1'b0}};
      rm_r           <= {IW{1'b0}};
      imm_r          <= {W{1'b0}};
      amt_r          <= 3'd0;
      opbarrel_r     <= 2'd0;
      aluctl_r       <= 2'd0;
      for (int i = 0; i < NREGS; i++) begin
        regfile_r[i] <= {W{1'b0}};
      end
      flags_r        <= 4'd0;
      alu_rn_r       <= {W{1'b0}};
      alu_rm_r       <= {W{1'b0}};
      alu_amt_r      <= 3'd0;
      alu_opbarrel_r <= 2'd0;
      alu_ctl_r      <= 2'd0;
      cond_pass_r    <= 1'b0;
      result_r       <= {W{1'b0}};
      nzcv_r         <= 4'd0;
      wb_valid_r     <= 1'b0;
      wb_exec_r      <= 1'b0;
      wb_data_r      <= {W{1'b0}};
    end else begin
      wb_valid_r <= 1'b0;
      wb_exec_r  <= 1'b0;
      wb_data_r  <= {W{1'b0}};
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            op_r       <= in_op;
            cond_r     <= in_cond;
            setf_r     <= in_setf;
            rd_r       <= in_rd;
            rn_r       <= in_rn;
            rm_r       <= in_rm;
            imm_r      <= in_imm;
            amt_r      <= in_amt;
            opbarrel_r <= in_opbarrel;
            aluctl_r   <= in_aluctl;
            in_ready_r <= 1'b0;
            state_r    <= READ;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        READ: begin
          // Operands are read here, before any write of this instruction.
          alu_rn_r       <= regfile_r[rn_r];
          alu_rm_r       <= regfile_r[rm_r];
          alu_amt_r      <= amt_r;
          alu_opbarrel_r <= opbarrel_r;
          alu_ctl_r      <= aluctl_r;
          cond_pass_r    <= cond_pass_s;
          state_r        <= EXEC;
        end
        EXEC: begin
          // Datapath is combinational from alu_* so its outputs are valid now.
          result_r <= alu_rd;
          nzcv_r   <= alu_nzcv;
          state_r  <= WB;
        end
        WB: begin
          if (reg_we_s) begin
            regfile_r[rd_r] <= wb_data_s;
          end
          if (flag_we_s) begin
            flags_r <= nzcv_r;
          end
          wb_valid_r <= 1'b1;
          wb_exec_r  <= cond_pass_r;
          wb_data_r  <= wb_data_s;
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign alu_rn       = alu_rn_r;
  assign alu_rm       = alu_rm_r;
  assign alu_amt      = alu_amt_r;
  assign alu_opbarrel = alu_opbarrel_r;
  assign alu_ctl      = alu_ctl_r;
  assign wb_valid     = wb_valid_r;
  assign wb_exec      = wb_exec_r;
  assign wb_data      = wb_data_r;
  assign flags        = flags_r;
  assign dbg_data     = regfile_r[dbg_idx];

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq: a reference ALU+barrel datapath is
// wired to the DUT, and an instruction-level model predicts every output.
module tb_alu_issue_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_op;
  logic [3:0] in_cond;
  logic       in_setf;
  logic [2:0] in_rd, in_rn, in_rm;
  logic [7:0] in_imm;
  logic [2:0] in_amt;
  logic [1:0] in_opbarrel, in_aluctl;
  logic [7:0] alu_rn, alu_rm;
  logic [2:0] alu_amt;
  logic [1:0] alu_opbarrel, alu_ctl;
  logic [7:0] alu_rd;
  logic [3:0] alu_nzcv;
  logic       wb_valid, wb_exec;
  logic [7:0] wb_data;
  logic [3:0] flags;
  logic [2:0] dbg_idx;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // DUT-observed events.
  int dut_acc = 0;
  int dut_wbn = 0;
  int last_acc_cyc = 0;
  int last_wb_cyc = 0;
  logic [7:0] last_wb_data = 8'h00;
  logic       last_wb_exec = 1'b0;
  int acc_q[$];

  // Instruction-level model state.
  logic [7:0] mregs [8];
  logic [3:0] mflags;
  int         cnt;
  logic       wb_now;
  logic       p_exec, p_wf;
  logic [7:0] p_data, p_a, p_b;
  logic [2:0] p_rd, p_amt;
  logic [1:0] p_opb, p_ctl;
  logic [3:0] p_nzcv;

  alu_issue_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cond(in_cond), .in_setf(in_setf), .in_rd(in_rd),
    .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm), .in_amt(in_amt),
    .in_opbarrel(in_opbarrel), .in_aluctl(in_aluctl), .alu_rn(alu_rn),
    .alu_rm(alu_rm), .alu_amt(alu_amt), .alu_opbarrel(alu_opbarrel),
    .alu_ctl(alu_ctl), .alu_rd(alu_rd), .alu_nzcv(alu_nzcv),
    .wb_valid(wb_valid), .wb_exec(wb_exec), .wb_data(wb_data), .flags(flags),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference datapath: barrel (LSL/LSR/ASR/ROR) on b, then add/sub/and/orr.
  function automatic logic [11:0] dp(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] amt, input logic [1:0] bop,
                                     input logic [1:0] ctl);
    logic [7:0]  op2, r;
    logic [8:0]  s;
    logic [15:0] dbl;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    dbl = {b, b} >> amt;
    case (bop)
      2'd0:    op2 = b << amt;
      2'd1:    op2 = b >> amt;
      2'd2:    op2 = $unsigned($signed(b) >>> amt);
      default: op2 = dbl[7:0];
    endcase
    case (ctl)
      2'd0: begin
        s = {1'b0, a} + {1'b0, op2};
        r = s[7:0]; c = s[8];
        v = (a[7] == op2[7]) && (r[7] != a[7]);
      end
      2'd1: begin
        s = {1'b0, a} + {1'b0, ~op2} + 9'd1;
        r = s[7:0]; c = s[8];
        v = (a[7] != op2[7]) && (r[7] != a[7]);
      end
      2'd2:    r = a & op2;
      default: r = a | op2;
    endcase
    return {r[7], (r == 8'h00), c, v, r};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    {n, z, cc, v} = f;
    case (c)
      4'd0:    return 1'b1;
      4'd1:    return z;
      4'd2:    return !z;
      4'd3:    return cc;
      4'd4:    return !cc;
      4'd5:    return cc && !z;
      4'd6:    return !cc || z;
      4'd7:    return n == v;
      4'd8:    return n != v;
      4'd9:    return !z && (n == v);
      4'd10:   return z || (n != v);
      4'd11:   return n;
      4'd12:   return !n;
      default: return 1'b0;
    endcase
  endfunction

  assign {alu_nzcv, alu_rd} = dp(alu_rn, alu_rm, alu_amt, alu_opbarrel, alu_ctl);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare process: check outputs against the model, then advance the model
  // across the coming rising edge.
  initial begin
    logic [11:0] dr;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mflags = 4'h0;
        cnt = 0;
        wb_now = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_alu_rn", {24'd0, alu_rn}, 32'd0);
      end else begin
        if (in_valid && in_ready) begin
          dut_acc++;
          last_acc_cyc = cyc + 1;
          acc_q.push_back(cyc + 1);
        end
        if (wb_valid) begin
          dut_wbn++;
          last_wb_cyc = cyc;
          last_wb_data = wb_data;
          last_wb_exec = wb_exec;
        end
        chk("in_ready", {31'd0, in_ready}, {31'd0, (cnt == 0)});
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, wb_now});
        if (wb_now) begin
          chk("wb_exec", {31'd0, wb_exec}, {31'd0, p_exec});
          chk("wb_data", {24'd0, wb_data}, {24'd0, (p_exec ? p_data : 8'h00)});
        end
        chk("flags", {28'd0, flags}, {28'd0, mflags});
        chk("dbg_data", {24'd0, dbg_data}, {24'd0, mregs[dbg_idx]});
        if (cnt == 2) begin
          chk("alu_rn", {24'd0, alu_rn}, {24'd0, p_a});
          chk("alu_rm", {24'd0, alu_rm}, {24'd0, p_b});
          chk("alu_ctrl", {25'd0, alu_amt, alu_opbarrel, alu_ctl},
              {25'd0, p_amt, p_opb, p_ctl});
        end
        wb_now = 1'b0;
        case (cnt)
          0: if (in_valid) begin
            p_a    = mregs[in_rn];
            p_b    = mregs[in_rm];
            p_amt  = in_amt;
            p_opb  = in_opbarrel;
            p_ctl  = in_aluctl;
            p_rd   = in_rd;
            p_exec = cond_ok(in_cond, mflags);
            dr     = dp(p_a, p_b, in_amt, in_opbarrel, in_aluctl);
            p_nzcv = dr[11:8];
            p_data = (in_op == OP_LDI) ? in_imm : dr[7:0];
            p_wf   = (in_op == OP_ALU) && in_setf && p_exec;
            cnt = 1;
          end
          1: cnt = 2;
          2: cnt = 3;
          default: begin
            if (p_exec) mregs[p_rd] = p_data;
            if (p_wf) mflags = p_nzcv;
            wb_now = 1'b1;
            cnt = 0;
          end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic op, input logic [3:0] cond, input logic setf,
                            input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                            input logic [7:0] imm, input logic [2:0] amt,
                            input logic [1:0] opb, input logic [1:0] ctl);
    in_op = op; in_cond = cond; in_setf = setf; in_rd = rd; in_rn = rn; in_rm = rm;
    in_imm = imm; in_amt = amt; in_opbarrel = opb; in_aluctl = ctl;
  endtask

  task automatic issue(input logic op, input logic [3:0] cond, input logic setf,
                       input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                       input logic [7:0] imm, input logic [2:0] amt,
                       input logic [1:0] opb, input logic [1:0] ctl);
    int a0, w0, t;
    set_fields(op, cond, setf, rd, rn, rm, imm, amt, opb, ctl);
    in_valid = 1'b1;
    a0 = dut_acc;
    t = 0;
    while (dut_acc == a0 && t < 16) begin step(); t++; end
    in_valid = 1'b0;
    chk("accepted", dut_acc - a0, 32'd1);
    w0 = dut_wbn;
    t = 0;
    while (dut_wbn == w0 && t < 16) begin step(); t++; end
    chk("wb_seen", dut_wbn - w0, 32'd1);
    chk("latency", last_wb_cyc - last_acc_cyc, 32'd3);
  endtask

  task automatic peek(input string nm, input logic [2:0] idx, input logic [7:0] exp);
    dbg_idx = idx;
    @(negedge clk);
    chk(nm, {24'd0, dbg_data}, {24'd0, exp});
    step();
  endtask

  initial begin
    int a0, w0, t;
    rst_n = 1'b0;
    in_valid = 1'b0;
    dbg_idx = 3'd0;
    set_fields(OP_ALU, 4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 3'd0, 2'd0, 2'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state: every register reads zero.
    for (int i = 0; i < 8; i++) peek("rst_reg", 3'(i), 8'h00);

    // LDI r1=5, r2=3.
    issue(OP_LDI, COND_AL, 1'b1, 3'd1, 3'd0, 3'd0, 8'h05, 3'd0, 2'd0, 2'd0);
    chk("ldi1_data", {24'd0, last_wb_data}, 32'h05);
    issue(OP_LDI, COND_AL, 1'b1, 3'd2, 3'd0, 3'd0, 8'h03, 3'd0, 2'd0, 2'd0);
    chk("ldi2_data", {24'd0, last_wb_data}, 32'h03);
    chk("ldi_flags", {28'd0, flags}, 32'h0);

    // r3 = r1 - r2, setf.
    issue(OP_ALU, COND_AL, 1'b1, 3'd3, 3'd1, 3'd2, 8'h00, 3'd0, 2'd0, 2'b01);
    peek("sub_r3", 3'd3, 8'h02);
    chk("sub_flags", {28'd0, flags}, 32'h2);

    // EQ add fails (Z=0), HS add passes (C=1).
    issue(OP_ALU, COND_EQ, 1'b0, 3'd4, 3'd1, 3'd2, 8'h00, 3'd0, 2'd0, 2'b00);
    chk("eq_exec", {31'd0, last_wb_exec}, 32'd0);
    chk("eq_data", {24'd0, last_wb_data}, 32'h0);
    peek("eq_r4", 3'd4, 8'h00);
    issue(OP_ALU, COND_HS, 1'b0, 3'd4, 3'd1, 3'd2, 8'h00, 3'd0, 2'd0, 2'b00);
    peek("hs_r4", 3'd4, 8'h08);

    // r6 = r5 - r5 with and without flag update.
    issue(OP_LDI, COND_AL, 1'b0, 3'd5, 3'd0, 3'd0, 8'h80, 3'd0, 2'd0, 2'd0);
    issue(OP_ALU, COND_AL, 1'b0, 3'd6, 3'd5, 3'd5, 8'h00, 3'd0, 2'd0, 2'b01);
    peek("sub0_r6", 3'd6, 8'h00);
    chk("nosetf_flags", {28'd0, flags}, 32'h2);
    issue(OP_ALU, COND_AL, 1'b1, 3'd6, 3'd5, 3'd5, 8'h00, 3'd0, 2'd0, 2'b01);
    chk("setf_flags", {28'd0, flags}, 32'h6);

    // Reset during EXEC aborts the instruction.
    set_fields(OP_LDI, COND_AL, 1'b0, 3'd7, 3'd0, 3'd0, 8'h55, 3'd0, 2'd0, 2'd0);
    in_valid = 1'b1;
    a0 = dut_acc;
    t = 0;
    while (dut_acc == a0 && t < 16) begin step(); t++; end
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    w0 = dut_wbn;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("abort_no_wb", dut_wbn - w0, 32'd0);
    peek("abort_r7", 3'd7, 8'h00);

    // Continuous in_valid with four distinct LDIs.
    a0 = dut_acc;
    acc_q.delete();
    set_fields(OP_LDI, COND_AL, 1'b0, 3'd1, 3'd0, 3'd0, 8'h11, 3'd0, 2'd0, 2'd0);
    in_valid = 1'b1;
    t = 0;
    while (dut_acc - a0 < 4 && t < 40) begin
      step();
      t++;
      if (dut_acc - a0 < 4)
        set_fields(OP_LDI, COND_AL, 1'b0, 3'(dut_acc - a0 + 1), 3'd0, 3'd0,
                   8'(8'h11 * (dut_acc - a0 + 1)), 3'd0, 2'd0, 2'd0);
    end
    in_valid = 1'b0;
    repeat (6) step();
    chk("cont_accepts", dut_acc - a0, 32'd4);
    for (int i = 1; i < 4 && i < acc_q.size(); i++)
      chk("cont_spacing", acc_q[i] - acc_q[i-1], 32'd4);
    peek("cont_r1", 3'd1, 8'h11);
    peek("cont_r2", 3'd2, 8'h22);
    peek("cont_r3", 3'd3, 8'h33);
    peek("cont_r4", 3'd4, 8'h44);

    // Randomized traffic, checked every cycle by the model.
    for (int k = 0; k < 900; k++) begin
      step();
      in_valid = ($urandom_range(0, 3) != 0);
      set_fields(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 3'($urandom),
                 8'($urandom), 3'($urandom), 2'($urandom), 2'($urandom));
      dbg_idx = 3'($urandom);
    end
    in_valid = 1'b0;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
